// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the multiplexed BCD seven-segment counter.
package seven_seg_pkg;

    typedef logic [3:0] bcd_t;

    // Segment codes, bit order {g,f,e,d,c,b,a}, active high
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam int DEF_MAX_COUNT = 10_000_000;
    localparam int DEF_SCAN_DIV  = 1024;

endpackage

// File: rtl/bcd_seg7_decode.sv
// Combinational BCD digit to seven-segment lookup; non-decimal codes blank.
module bcd_seg7_decode
    import seven_seg_pkg::*;
(
    input  bcd_t       i_digit,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_digit)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_segment_counter_mux.sv
// N-digit BCD up/down counter on a programmable prescaler tick, driving one
// scanned seven-segment display. Define SEVEN_SEG_LZB_EN for leading-zero blanking.
module seven_segment_counter_mux
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE_W = 24,
    parameter int MAX_COUNT  = DEF_MAX_COUNT,
    parameter int SCAN_DIV   = DEF_SCAN_DIV
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ena,
    input  logic [7:0]              cmp_sel,
    input  logic                    up_dn,
    input  logic                    pause,
    input  logic                    clear,
    output logic [6:0]              segments,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    tick,
    output logic                    wrap,
    output logic [4*NUM_DIGITS-1:0] bcd_value
);

    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PRESCALE_W-1:0] MAX_T    = PRESCALE_W'(MAX_COUNT);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic [PRESCALE_W-1:0]   r_pre;
    logic [PRESCALE_W-1:0]   w_term;
    bcd_t [NUM_DIGITS-1:0]   r_digits;
    bcd_t [NUM_DIGITS-1:0]   w_digits_nxt;
    logic                    w_roll;
    logic                    r_tick;
    logic                    r_wrap;
    logic [SCAN_W-1:0]       r_scan_cnt;
    logic [IDX_W-1:0]        r_scan_idx;
    logic [NUM_DIGITS-1:0]   r_digit_sel;
    logic [NUM_DIGITS-1:0]   w_sel_onehot;
    logic [6:0]              r_segments;
    logic [6:0]              w_dec_seg;
    bcd_t                    w_cur_digit;
    logic                    w_blank;

    assign w_term = (cmp_sel == 8'd0) ? MAX_T : PRESCALE_W'({cmp_sel, 10'b0});

    // Ripple carry/borrow through all digits in one cycle; w_roll survives to
    // the end only when every digit rolled over.
    always_comb begin
        w_digits_nxt = r_digits;
        w_roll       = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (w_roll) begin
                if (up_dn) begin
                    if (r_digits[k] == 4'd9) begin
                        w_digits_nxt[k] = 4'd0;
                    end else begin
                        w_digits_nxt[k] = r_digits[k] + 4'd1;
                        w_roll          = 1'b0;
                    end
                end else begin
                    if (r_digits[k] == 4'd0) begin
                        w_digits_nxt[k] = 4'd9;
                    end else begin
                        w_digits_nxt[k] = r_digits[k] - 4'd1;
                        w_roll          = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre    <= '0;
            r_digits <= '0;
            r_tick   <= 1'b0;
            r_wrap   <= 1'b0;
        end else if (clear) begin
            r_pre    <= '0;
            r_digits <= '0;
            r_tick   <= 1'b0;
            r_wrap   <= 1'b0;
        end else if (pause || !ena) begin
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end else if (r_pre == w_term) begin
            r_pre    <= '0;
            r_digits <= w_digits_nxt;
            r_tick   <= 1'b1;
            r_wrap   <= w_roll;
        end else begin
            r_pre  <= r_pre + 1'b1;
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end
    end

    assign w_cur_digit = r_digits[r_scan_idx];

    bcd_seg7_decode u_decode (
        .i_digit (w_cur_digit),
        .o_seg   (w_dec_seg)
    );

`ifdef SEVEN_SEG_LZB_EN
    logic [NUM_DIGITS-1:0] w_upper_zero;

    // w_upper_zero[k]: digit k and every digit above it are zero
    always_comb begin
        w_upper_zero = '0;
        w_upper_zero[NUM_DIGITS-1] = (r_digits[NUM_DIGITS-1] == 4'd0);
        for (int k = NUM_DIGITS - 2; k >= 0; k--) begin
            w_upper_zero[k] = w_upper_zero[k+1] && (r_digits[k] == 4'd0);
        end
    end

    assign w_blank = (r_scan_idx != '0) && w_upper_zero[r_scan_idx];
`else
    assign w_blank = 1'b0;
`endif

    always_comb begin
        w_sel_onehot             = '0;
        w_sel_onehot[r_scan_idx] = 1'b1;
    end

    // Select and segment registers load from the same index so they never disagree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt  <= '0;
            r_scan_idx  <= '0;
            r_digit_sel <= NUM_DIGITS'(1);
            r_segments  <= SEG_0;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
            if (&r_scan_cnt) begin
                r_scan_idx <= (r_scan_idx == LAST_IDX) ? '0 : r_scan_idx + 1'b1;
            end
            r_digit_sel <= w_sel_onehot;
            r_segments  <= w_blank ? SEG_BLANK : w_dec_seg;
        end
    end

    assign segments  = r_segments;
    assign digit_sel = r_digit_sel;
    assign tick      = r_tick;
    assign wrap      = r_wrap;
    assign bcd_value = r_digits;

endmodule
